// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens (shared with the encoder), receiver state, decoded character.
// Combinational only (no latency, no backpressure); tmds_decoder optionally builds stats under TMDS_DECODER_STATS_EN.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic [7:0] data;
  } char_t;

  function automatic logic is_ctrl_token(input logic [9:0] c);
    return (c == CTRL_TOKEN_00) || (c == CTRL_TOKEN_01) ||
           (c == CTRL_TOKEN_10) || (c == CTRL_TOKEN_11);
  endfunction

endpackage

// File: rtl/tmds_char_decode.sv
// Decodes one aligned 10-bit TMDS character into a control value or a video byte.
// Purely combinational: zero latency, no backpressure.
module tmds_char_decode
  import tmds_pkg::*;
(
  input  logic [9:0] char_i,
  output char_t      dec_o
);

  logic [7:0] p;

  always_comb begin
    dec_o = '0;
    p     = char_i[9] ? ~char_i[7:0] : char_i[7:0];
    case (char_i)
      CTRL_TOKEN_00: begin dec_o.is_ctrl = 1'b1; dec_o.ctrl = 2'b00; end
      CTRL_TOKEN_01: begin dec_o.is_ctrl = 1'b1; dec_o.ctrl = 2'b01; end
      CTRL_TOKEN_10: begin dec_o.is_ctrl = 1'b1; dec_o.ctrl = 2'b10; end
      CTRL_TOKEN_11: begin dec_o.is_ctrl = 1'b1; dec_o.ctrl = 2'b11; end
      default: begin
        // char_i[8] selects XOR vs XNOR chaining used by the encoder
        dec_o.data[0] = p[0];
        for (int i = 1; i < 8; i++) begin
          dec_o.data[i] = char_i[8] ? (p[i] ^ p[i-1]) : ~(p[i] ^ p[i-1]);
        end
      end
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// One TMDS channel receiver: locks character alignment on control tokens, decodes with 2-cycle latency, no backpressure.
// Define TMDS_DECODER_STATS_EN to build the saturating lock-loss counter on loss_count_out (tied to 0 otherwise).
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS = 16,
  parameter int MAX_GAP     = 2048
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  data_out,
  output logic [1:0]  control_out,
  output logic        ve_out,
  output logic        locked_out,
  output logic [3:0]  offset_out,
  output logic [15:0] loss_count_out
);

  localparam int CNT_W = $clog2(LOCK_TOKENS + 1);
  localparam int GAP_W = $clog2(MAX_GAP);
  localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_TOKENS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 2);

  logic [9:0]       prev_q;
  logic [19:0]      window_d, win_q;
  logic [9:0]       match_d, match_q;
  state_e           state_q;
  logic [3:0]       cand_q, offset_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       data_q;
  logic [1:0]       ctrl_q;
  logic             ve_q, locked_q;
  logic             hit_any, loss_now;
  logic [3:0]       hit_k, sel_off;
  logic [9:0]       sel_char;
  char_t            dec;

  assign window_d = {tmds_in, prev_q};

  always_comb begin
    match_d = '0;
    for (int k = 0; k < 10; k++) begin
      match_d[k] = is_ctrl_token(window_d[k +: 10]);
    end
  end

  // Stage 1; the window arriving on a lock-loss edge is dropped so hunting restarts clean
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev_q  <= '0;
      win_q   <= '0;
      match_q <= '0;
    end else begin
      prev_q  <= tmds_in;
      win_q   <= loss_now ? '0 : window_d;
      match_q <= loss_now ? '0 : match_d;
    end
  end

  always_comb begin
    hit_any = 1'b0;
    hit_k   = '0;
    for (int k = 9; k >= 0; k--) begin
      if (match_q[k]) begin
        hit_any = 1'b1;
        hit_k   = 4'(k);
      end
    end
  end

  assign cnt_inc  = (hit_k == cand_q) ? cnt_q + 1'b1 : CNT_W'(1);
  assign loss_now = (state_q == LOCKED) && !match_q[offset_q] && (gap_q == GAP_LAST);
  // On the locking edge the new offset is hit_k, so decode from it directly
  assign sel_off  = (state_q == LOCKED) ? offset_q : hit_k;
  assign sel_char = 10'(win_q >> sel_off);

  tmds_char_decode u_char_decode (
    .char_i (sel_char),
    .dec_o  (dec)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= HUNT;
      cand_q   <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      ve_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          data_q <= '0;
          ctrl_q <= '0;
          ve_q   <= 1'b0;
          if (hit_any) begin
            cand_q   <= hit_k;
            offset_q <= hit_k;
            cnt_q    <= cnt_inc;
            if (cnt_inc == CNT_LOCK) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              gap_q    <= '0;
              ctrl_q   <= dec.ctrl;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        LOCKED: begin
          if (loss_now) begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            ctrl_q   <= '0;
            ve_q     <= 1'b0;
          end else begin
            gap_q <= match_q[offset_q] ? '0 : gap_q + 1'b1;
            if (dec.is_ctrl) begin
              ve_q   <= 1'b0;
              ctrl_q <= dec.ctrl;
              data_q <= '0;
            end else begin
              ve_q   <= 1'b1;
              data_q <= dec.data;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] loss_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      loss_q <= '0;
    end else if (loss_now && (loss_q != 16'hFFFF)) begin
      loss_q <= loss_q + 16'd1;
    end
  end

  assign loss_count_out = loss_q;
`else
  assign loss_count_out = 16'h0000;
`endif

  assign data_out    = data_q;
  assign control_out = ctrl_q;
  assign ve_out      = ve_q;
  assign locked_out  = locked_q;
  assign offset_out  = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: bit-stream stimulus, per-window reference model, decoupled output monitor.
// Honours TMDS_DECODER_STATS_EN when predicting loss_count_out.
module tb_tmds_decoder;

  localparam int LOCK   = 16;
  localparam int MAXGAP = 2048;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [9:0]  tmds_in;
  logic [7:0]  data_out;
  logic [1:0]  control_out;
  logic        ve_out;
  logic        locked_out;
  logic [3:0]  offset_out;
  logic [15:0] loss_count_out;

  tmds_decoder #(.LOCK_TOKENS(LOCK), .MAX_GAP(MAXGAP)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tmds_in        (tmds_in),
    .data_out       (data_out),
    .control_out    (control_out),
    .ve_out         (ve_out),
    .locked_out     (locked_out),
    .offset_out     (offset_out),
    .loss_count_out (loss_count_out)
  );

  always #5 clk_in = ~clk_in;

  int pcnt = 0;
  always @(posedge clk_in) pcnt <= pcnt + 1;

  typedef struct {
    int          due;
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic        ve;
    logic        locked;
    logic [3:0]  off;
    logic [15:0] loss;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic bitq[$];

  logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  // Reference model state
  logic [9:0]  m_prev;
  bit          m_locked, m_discard;
  int          m_cand, m_cnt, m_gap, m_off;
  logic [15:0] m_loss;
  logic [7:0]  m_data;
  logic [1:0]  m_ctrl;
  logic        m_ve;

  function automatic int tok_idx(input logic [9:0] c);
    for (int t = 0; t < 4; t++) if (c == TOK[t]) return t;
    return -1;
  endfunction

  // Undo the encoder: strip optional inversion, then undo the running XOR/XNOR chain.
  function automatic logic [7:0] ref_data(input logic [9:0] q);
    logic [7:0] p;
    p = q[9] ? ~q[7:0] : q[7:0];
    return (p ^ {p[6:0], 1'b0}) ^ (q[8] ? 8'h00 : 8'hFE);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (tok_idx(w) >= 0);
    return w;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_locked = 0; m_discard = 0;
    m_cand = 0; m_cnt = 0; m_gap = 0; m_off = 0;
    m_loss = '0; m_data = '0; m_ctrl = '0; m_ve = 1'b0;
  endtask

  task automatic model_step(input logic [19:0] w);
    int hit;
    int t;
    logic [9:0] c;
    hit = -1;
    for (int k = 9; k >= 0; k--) begin
      c = w[k +: 10];
      if (tok_idx(c) >= 0) hit = k;
    end
    if (m_discard) begin
      hit = -1;
      m_discard = 0;
    end
    if (!m_locked) begin
      if (hit >= 0) begin
        if (hit == m_cand) m_cnt++;
        else begin m_cand = hit; m_cnt = 1; end
      end else m_cnt = 0;
      m_off = m_cand;
      if (m_cnt == LOCK) begin m_locked = 1; m_gap = 0; end
    end else begin
      c = w[m_off +: 10];
      if (tok_idx(c) >= 0) m_gap = 0; else m_gap++;
      if (m_gap == MAXGAP - 1) begin
        m_locked = 0; m_cnt = 0; m_gap = 0; m_discard = 1;
        if (m_loss != 16'hFFFF) m_loss++;
      end
    end
    if (m_locked) begin
      c = w[m_off +: 10];
      t = tok_idx(c);
      if (t >= 0) begin m_ve = 0; m_ctrl = 2'(t); m_data = 8'h00; end
      else begin m_ve = 1; m_data = ref_data(c); end
    end else begin
      m_ve = 0; m_ctrl = 2'b00; m_data = 8'h00;
    end
  endtask

  task automatic send(input logic [9:0] w);
    exp_t e;
    @(posedge clk_in);
    #1;
    tmds_in = w;
    model_step({w, m_prev});
    m_prev = w;
    e.due = pcnt + 2;
    e.data = m_data; e.ctrl = m_ctrl; e.ve = m_ve;
    e.locked = m_locked; e.off = 4'(m_off);
`ifdef TMDS_DECODER_STATS_EN
    e.loss = m_loss;
`else
    e.loss = 16'h0000;
`endif
    sbq.push_back(e);
  endtask

  task automatic start_stream(input int shift);
    bitq.delete();
    repeat (shift) bitq.push_back(1'($urandom_range(0, 1)));
  endtask

  // Character bits go on the wire LSB first; words are cut from the stream irrespective of alignment.
  task automatic emit(input logic [9:0] c);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) bitq.push_back(c[i]);
    for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
    send(w);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk_in);
    #2;
    rst_in  = 1'b1;
    tmds_in = '0;
    #1;
    if (check)
      check_now("reset_async", {data_out, control_out, ve_out, locked_out, offset_out, loss_count_out}, 32'h0);
    sbq.delete();
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && sbq.size() > 0 && sbq[0].due <= pcnt) begin
      mon_e = sbq.pop_front();
      n_cmp++;
      if (mon_e.due != pcnt) begin
        n_bad++;
        $display("FAIL sb_missed: expectation due at %0d seen at %0d", mon_e.due, pcnt);
      end else if ({data_out, control_out, ve_out, locked_out, offset_out, loss_count_out} !==
                   {mon_e.data, mon_e.ctrl, mon_e.ve, mon_e.locked, mon_e.off, mon_e.loss}) begin
        n_bad++;
        $display("FAIL sb cyc=%0d got d=%h c=%h ve=%b lk=%b off=%0d loss=%0d exp d=%h c=%h ve=%b lk=%b off=%0d loss=%0d",
                 pcnt, data_out, control_out, ve_out, locked_out, offset_out, loss_count_out,
                 mon_e.data, mon_e.ctrl, mon_e.ve, mon_e.locked, mon_e.off, mon_e.loss);
      end
    end
  end

  initial begin
    #3_000_000;
    n_bad++;
    $display("FAIL timeout: bench did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [15:0] exp_loss;
    rst_in  = 1'b1;
    tmds_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_now("reset_init", {data_out, control_out, ve_out, locked_out, offset_out, loss_count_out}, 32'h0);
    rst_in = 1'b0;

    // Aligned lock on token 00
    start_stream(0);
    repeat (17) emit(TOK[0]);
    repeat (3) emit(TOK[0]);
    check_now("aligned_lock", {locked_out, offset_out, control_out, ve_out}, {1'b1, 4'd0, 2'b00, 1'b0});

    // Data decode at offset 0
    emit(10'b0111111111);
    emit(10'b0100000000);
    emit(TOK[0]);
    emit(TOK[0]);
    check_now("decode_01", {ve_out, data_out}, {1'b1, 8'h01});
    emit(TOK[0]);
    check_now("decode_00", {ve_out, data_out}, {1'b1, 8'h00});

    // Lock loss after MAX_GAP token-free cycles
    for (int i = 1; i <= MAXGAP; i++) begin
      emit(rand_data());
      if (i == MAXGAP - 1) check_now("pre_loss_locked", 32'(locked_out), 32'd1);
    end
    emit(rand_data());
    emit(rand_data());
    check_now("loss_outputs", {locked_out, ve_out, control_out, data_out}, 32'h0);
`ifdef TMDS_DECODER_STATS_EN
    exp_loss = 16'd1;
`else
    exp_loss = 16'd0;
`endif
    check_now("loss_count", 32'(loss_count_out), 32'(exp_loss));
    repeat (20) emit(TOK[0]);
    check_now("relock", 32'(locked_out), 32'd1);

    // Shifted lock at offset 3 with alternating tokens 01 / 10
    do_reset(1);
    start_stream(3);
    for (int i = 0; i < 22; i++) emit((i % 2) ? TOK[2] : TOK[1]);
    check_now("shift_lock", {locked_out, offset_out}, {1'b1, 4'd3});

    // Reset mid-stream while locked at a nonzero offset
    do_reset(1);

    // Interrupted hunt
    start_stream(0);
    repeat (10) emit(TOK[3]);
    emit(10'b0111111111);
    emit(TOK[3]);
    emit(TOK[3]);
    check_now("hunt_no_lock", 32'(locked_out), 32'd0);
    repeat (14) emit(TOK[3]);
    repeat (3) emit(TOK[3]);
    check_now("hunt_relock", 32'(locked_out), 32'd1);

    // Randomized traffic at random bit offsets
    repeat (2) begin
      do_reset(0);
      start_stream(int'($urandom_range(0, 9)));
      repeat (24) emit(TOK[$urandom_range(0, 3)]);
      repeat (400) begin
        if ($urandom_range(0, 99) < 35) emit(TOK[$urandom_range(0, 3)]);
        else emit(rand_data());
      end
    end

    repeat (4) @(posedge clk_in);
    #1;
    check_now("sb_drain", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
